// File: rtl/spu_rf_fwd.sv
// Register-fetch / forwarding stage in front of the even-pipe shift/rotate unit.
// Optional feature macro: SPU_RF_BYPASS_EN (writeback bypass, scoreboard depth EXE_LAT).
module spu_rf_fwd #(
  parameter int EXE_LAT = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [10:0]  in_op,
  input  logic [2:0]   in_format,
  input  logic [6:0]   in_rt_addr,
  input  logic [6:0]   in_ra_addr,
  input  logic [6:0]   in_rb_addr,
  input  logic         in_ra_rd,
  input  logic         in_rb_rd,
  input  logic [17:0]  in_imm,
  input  logic         in_reg_write,
  output logic [10:0]  op,
  output logic [2:0]   format,
  output logic [6:0]   rt_addr,
  output logic [17:0]  imm,
  output logic         reg_write,
  output logic [127:0] ra,
  output logic [127:0] rb,
  input  logic [127:0] rt_wb,
  input  logic [6:0]   rt_addr_wb,
  input  logic         reg_write_wb
);

`ifdef SPU_RF_BYPASS_EN
  localparam int SB_DEPTH = EXE_LAT;
`else
  localparam int SB_DEPTH = EXE_LAT + 1;
`endif

  logic [127:0]         rf [128];
  logic [127:0]         ra_val;
  logic [127:0]         rb_val;
  logic [SB_DEPTH-1:0]  sb_v;
  logic [6:0]           sb_addr [SB_DEPTH];
  logic [SB_DEPTH-1:0]  ra_hit;
  logic [SB_DEPTH-1:0]  rb_hit;
  logic                 hazard;
  logic                 accept;

  // Register file held in flops so the whole array clears on reset.
  genvar gi;
  generate
    for (gi = 0; gi < 128; gi++) begin : g_rf
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rf[gi] <= '0;
        end else if (reg_write_wb && (rt_addr_wb == 7'(gi))) begin
          rf[gi] <= rt_wb;
        end
      end
    end
  endgenerate

`ifdef SPU_RF_BYPASS_EN
  assign ra_val = (reg_write_wb && (rt_addr_wb == in_ra_addr)) ? rt_wb : rf[in_ra_addr];
  assign rb_val = (reg_write_wb && (rt_addr_wb == in_rb_addr)) ? rt_wb : rf[in_rb_addr];
`else
  assign ra_val = rf[in_ra_addr];
  assign rb_val = rf[in_rb_addr];
`endif

  // Entry 0 is the instruction currently on the issue outputs.
  assign sb_v[0]    = reg_write;
  assign sb_addr[0] = rt_addr;

  generate
    for (gi = 1; gi < SB_DEPTH; gi++) begin : g_sb
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sb_v[gi]    <= 1'b0;
          sb_addr[gi] <= '0;
        end else begin
          sb_v[gi]    <= sb_v[gi-1];
          sb_addr[gi] <= sb_addr[gi-1];
        end
      end
    end
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_hit
      assign ra_hit[gi] = sb_v[gi] && (sb_addr[gi] == in_ra_addr);
      assign rb_hit[gi] = sb_v[gi] && (sb_addr[gi] == in_rb_addr);
    end
  endgenerate

  assign hazard   = in_valid && ((in_ra_rd && (|ra_hit)) || (in_rb_rd && (|rb_hit)));
  assign in_ready = ~reset & ~hazard;
  assign accept   = in_valid & in_ready;

  // Issue bundle: accepted instruction or an all-zero bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      ra        <= '0;
      rb        <= '0;
    end else if (accept) begin
      op        <= in_op;
      format    <= in_format;
      rt_addr   <= in_rt_addr;
      imm       <= in_imm;
      reg_write <= in_reg_write;
      ra        <= ra_val;
      rb        <= rb_val;
    end else begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
      ra        <= '0;
      rb        <= '0;
    end
  end

endmodule
